// File: rtl/facto_host_pkg.sv
// Shared types and constants for the facto_host bus-master sequencer.
package facto_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_WR_INTEN,
    S_WR_OPERAND,
    S_WR_START,
    S_WAIT,
    S_POLL_RD,
    S_POLL_CHK,
    S_RD_H,
    S_CAP_H,
    S_RD_L,
    S_CAP_L,
    S_WR_RAM_H,
    S_WR_RAM_L,
    S_WR_CLEAR,
    S_DONE
  } state_e;

  localparam logic [15:0] OFS_OPSTART  = 16'h0000;
  localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
  localparam logic [15:0] OFS_OPDONE   = 16'h0010;
  localparam logic [15:0] OFS_INTREN   = 16'h0018;
  localparam logic [15:0] OFS_OPERAND  = 16'h0020;
  localparam logic [15:0] OFS_RESULT_H = 16'h0028;
  localparam logic [15:0] OFS_RESULT_L = 16'h0030;

  localparam int RESULT_SLOTS = 2;

  // States that issue a bus transfer and therefore stall while grant is low.
  function automatic logic is_xfer(input state_e s);
    return s inside {S_WR_INTEN, S_WR_OPERAND, S_WR_START, S_POLL_RD, S_RD_H,
                     S_RD_L, S_WR_RAM_H, S_WR_RAM_L, S_WR_CLEAR};
  endfunction

endpackage

// File: rtl/facto_host.sv
// Single-job factorial sequencer driving the bus master port of FactoCore + ram.
// FACTO_HOST_IRQ_EN selects interrupt-driven completion; otherwise opdone is polled.
//
// state        | meaning
// IDLE         | waiting for a command, cmd_ready high
// REQ          | bus requested, waiting for first grant
// WR_INTEN     | write intrEn (1 with IRQ, 0 when polling)
// WR_OPERAND   | write operand N
// WR_START     | write opstart=1
// WAIT         | IRQ: wait for interrupt; polling: POLL_GAP idle cycles
// POLL_RD      | read opdone
// POLL_CHK     | opdone data phase, bit0 decides RD_H or another WAIT
// RD_H / RD_L  | read result_h / result_l
// CAP_H / CAP_L| capture read data
// WR_RAM_H/L   | store result words at dst and dst+1
// WR_CLEAR     | write opclear=1
// DONE         | release bus, pulse done
module facto_host
  import facto_host_pkg::*;
#(
  parameter logic [15:0] FACTO_BASE = 16'h7000,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_operand,
  input  logic [15:0] cmd_dst,
  output logic        done,
  output logic        busy,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic        m_grant,
  input  logic [63:0] m_din,
  input  logic        interrupt
);

`ifdef FACTO_HOST_IRQ_EN
  localparam logic [63:0] INTEN_VAL = 64'd1;
`else
  localparam logic [63:0] INTEN_VAL = 64'd0;
  logic irq_unused;
  assign irq_unused = interrupt;
  logic [3:0] cnt_q, cnt_d;
`endif

  state_e      state_q, state_d;
  logic [63:0] operand_q, operand_d;
  logic [15:0] dst_q, dst_d;
  logic [63:0] res_h_q, res_h_d;
  logic [63:0] res_l_q, res_l_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        m_req_q, m_req_d;
  logic        m_wr_q, m_wr_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [63:0] m_dout_q, m_dout_d;

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    dst_d     = dst_q;
    res_h_d   = res_h_q;
    res_l_d   = res_l_q;
`ifndef FACTO_HOST_IRQ_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          operand_d = cmd_operand;
          dst_d     = cmd_dst;
          state_d   = S_REQ;
        end
      end
      S_REQ:        if (m_grant) state_d = S_WR_INTEN;
      S_WR_INTEN:   state_d = S_WR_OPERAND;
      S_WR_OPERAND: state_d = S_WR_START;
      S_WR_START: begin
        state_d = S_WAIT;
`ifndef FACTO_HOST_IRQ_EN
        cnt_d   = 4'(POLL_GAP - 1);
`endif
      end
`ifdef FACTO_HOST_IRQ_EN
      S_WAIT:       if (interrupt) state_d = S_RD_H;
`else
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_POLL_RD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_POLL_RD:    state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (m_din[0]) begin
          state_d = S_RD_H;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(POLL_GAP - 1);
        end
      end
`endif
      S_RD_H:       state_d = S_CAP_H;
      S_CAP_H: begin
        res_h_d = m_din;
        state_d = S_RD_L;
      end
      S_RD_L:       state_d = S_CAP_L;
      S_CAP_L: begin
        res_l_d = m_din;
        state_d = S_WR_RAM_H;
      end
      S_WR_RAM_H:   state_d = S_WR_RAM_L;
      S_WR_RAM_L:   state_d = S_WR_CLEAR;
      S_WR_CLEAR:   state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    if (is_xfer(state_q) && !m_grant) state_d = state_q;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    m_wr_d      = 1'b0;
    m_addr_d    = 16'h0000;
    m_dout_d    = 64'd0;
    m_req_d     = !(state_d inside {S_IDLE, S_DONE});
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    case (state_d)
      S_WR_INTEN:   begin m_wr_d = 1'b1; m_addr_d = FACTO_BASE + OFS_INTREN;  m_dout_d = INTEN_VAL; end
      S_WR_OPERAND: begin m_wr_d = 1'b1; m_addr_d = FACTO_BASE + OFS_OPERAND; m_dout_d = operand_d; end
      S_WR_START:   begin m_wr_d = 1'b1; m_addr_d = FACTO_BASE + OFS_OPSTART; m_dout_d = 64'd1; end
      S_POLL_RD:    m_addr_d = FACTO_BASE + OFS_OPDONE;
      S_RD_H:       m_addr_d = FACTO_BASE + OFS_RESULT_H;
      S_RD_L:       m_addr_d = FACTO_BASE + OFS_RESULT_L;
      S_WR_RAM_H:   begin m_wr_d = 1'b1; m_addr_d = dst_d; m_dout_d = res_h_d; end
      S_WR_RAM_L:   begin m_wr_d = 1'b1; m_addr_d = dst_d + 16'(RESULT_SLOTS - 1); m_dout_d = res_l_d; end
      S_WR_CLEAR:   begin m_wr_d = 1'b1; m_addr_d = FACTO_BASE + OFS_OPCLEAR; m_dout_d = 64'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      operand_q   <= 64'd0;
      dst_q       <= 16'h0000;
      res_h_q     <= 64'd0;
      res_l_q     <= 64'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= 16'h0000;
      m_dout_q    <= 64'd0;
`ifndef FACTO_HOST_IRQ_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      dst_q       <= dst_d;
      res_h_q     <= res_h_d;
      res_l_q     <= res_l_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      m_req_q     <= m_req_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_dout_q    <= m_dout_d;
`ifndef FACTO_HOST_IRQ_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_dout    = m_dout_q;

endmodule
